// File: rtl/boot_pkg.sv
// Shared types and default geometry for the boot ROM to instruction RAM copier.
package boot_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} copier_state_e;

  localparam int          DEF_ROM_AW   = 10;
  localparam int          DEF_DST_AW   = 16;
  localparam logic [15:0] DEF_DST_BASE = 16'h0000;
endpackage

// File: rtl/boot_rom_copier.sv
// Streams n words from the boot ROM into instruction RAM, sums them, then releases the core.
module boot_rom_copier
  import boot_pkg::*;
#(
  parameter int                ROM_AW   = DEF_ROM_AW,
  parameter int                DST_AW   = DEF_DST_AW,
  parameter logic [DST_AW-1:0] DST_BASE = DST_AW'(DEF_DST_BASE)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start_i,
  input  logic [ROM_AW:0]   len_i,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DST_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       checksum_o,
  output logic              fetch_enable_o
);
  localparam int            CW    = ROM_AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ROM_AW;

  copier_state_e     state_q, state_d;
  logic [CW-1:0]     idx_q, n_q, n_in, idx_nxt;
  logic [ROM_AW-1:0] addr_q;
  logic [31:0]       sum_q;
  logic              fe_q, accept, last, wr_ok;

  assign n_in    = (len_i > DEPTH) ? DEPTH : len_i;
  assign accept  = (state_q == IDLE) && start_i;
  assign idx_nxt = idx_q + CW'(1);
  assign last    = idx_nxt >= n_q;
  assign wr_ok   = (state_q == WRITE) && mem_gnt_i;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!rom_csn_o) addr_q <= rom_addr_o;
      if (accept) begin
        idx_q <= '0;
        n_q   <= n_in;
        sum_q <= '0;
      end
      if (wr_ok) begin
        sum_q <= sum_q + rom_rdata_i;
        idx_q <= idx_nxt;
      end
      if (state_q == DONE) fe_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (n_in == '0) ? DONE : FETCH;
      FETCH:   state_d = WRITE;
      WRITE:   if (mem_gnt_i && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next ROM read is only launched in the cycle the current word is granted,
  // so ROM Q never changes under an outstanding request.
  always_comb begin
    rom_csn_o  = 1'b1;
    rom_addr_o = addr_q;
    if (accept && (n_in != '0)) begin
      rom_csn_o  = 1'b0;
      rom_addr_o = '0;
    end else if (wr_ok && !last) begin
      rom_csn_o  = 1'b0;
      rom_addr_o = idx_nxt[ROM_AW-1:0];
    end
  end

  assign mem_req_o      = (state_q == WRITE);
  assign mem_we_o       = mem_req_o;
  assign mem_be_o       = 4'hF;
  assign mem_addr_o     = DST_BASE + (DST_AW'(idx_q) << 2);
  assign mem_wdata_o    = rom_rdata_i;
  assign busy_o         = (state_q == FETCH) || (state_q == WRITE);
  assign done_o         = (state_q == DONE);
  assign checksum_o     = sum_q;
  assign fetch_enable_o = fe_q;
endmodule
